multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences the PC, the memory port, the IR, the register file and the shared ALU.
- Generates the 2-bit aluop consumed by alu_control:
  - 0 = add
  - 1 = subtract
  - 2 = use funct field
  - 3 = add
- Handshakes with a variable-latency memory through mem_ready.
- A watchdog halts the core on a memory timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles a memory state may wait with mem_ready low before halting (1..255).
- CNT_W, 8: width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]; sampled in DECODE
- mem_ready  input  1  memory completes the current access this cycle
- pcwrite  output  1  unconditional PC load
- pcwritecond  output  1  PC load if ALU zero (beq)
- iord  output  1  0 = address from PC, 1 = address from ALUOut
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- irwrite  output  1  IR load
- memtoreg  output  1  write-back source: 1 = MDR, 0 = ALUOut
- regdst  output  1  1 = rd, 0 = rt
- regwrite  output  1  register file write
- alusrca  output  1  0 = PC, 1 = rs
- alusrcb  output  2  0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- aluop  output  2  to alu_control
- pcsource  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- state  output  4  current state encoding (debug/verification)
- illegal  output  1  one-cycle pulse on an unrecognised opcode
- err  output  1  sticky memory-timeout flag

Behaviour:
- Reset:
  - While reset=1, all control outputs are driven 0 (pcwrite..pcsource, illegal; err cleared), the wait counter is cleared, and the next state is FETCH.
  - Reset wins over every other event, including reset mid-wait or in HALT.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15.
- Outputs are decoded from state only, except the mem_ready gating noted below. Outputs not listed for a state are 0.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=1, aluop=0, pcsource=0.
  - irwrite=pcwrite=mem_ready.
  - If mem_ready=1, go to DECODE; otherwise stay.
- DECODE:
  - alusrca=0, alusrcb=3, aluop=0 (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 -> EXEC
    - 0x23 or 0x2B -> MEMADR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDIEX (only when the optional feature is compiled in)
    - anything else -> FETCH, with illegal=1 for exactly that cycle.
- MEMADR:
  - alusrca=1, alusrcb=2, aluop=0.
  - Next: MEMRD for 0x23, MEMWR for 0x2B (opcode held stable by the IR).
- MEMRD:
  - memread=1, iord=1.
  - If mem_ready=1, go to MEMWB; otherwise stay.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next: FETCH.
- MEMWR:
  - memwrite=1, iord=1.
  - If mem_ready=1, go to FETCH; otherwise stay.
- EXEC: alusrca=1, alusrcb=0, aluop=2. Next: ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Next: FETCH.
- BRANCH: alusrca=1, alusrcb=0, aluop=1, pcwritecond=1, pcsource=1. Next: FETCH.
- JUMP: pcwrite=1, pcsource=2. Next: FETCH.
- Instruction latencies (zero-wait memory):
  - R-type 4 cycles
  - lw 5, sw 4
  - beq 3, j 3
  - addi 4
- Watchdog:
  - In FETCH, MEMRD and MEMWR, the counter increments each cycle mem_ready=0. It is cleared on any state change.
  - When counter == MEM_WAIT_MAX and mem_ready=0, the next state is HALT and err is set to 1.
  - If mem_ready=1 in that same cycle, the access completes normally (ready beats timeout).
- HALT: all control outputs 0, err=1; remains in HALT until reset.
- Counter saturates; no wrap-around.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ADDI_EN.
- Defined:
  - DECODE maps 0x08 to ADDIEX.
  - ADDIEX: alusrca=1, alusrcb=2, aluop=0. Next: ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next: FETCH.
- Undefined: states 10 and 11 are unreachable; 0x08 is treated as illegal (pulse, return to FETCH).

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and opcode=0x00 -> state 0,1,6,7,0. aluop=2 in EXEC; regwrite=1 and regdst=1 in ALUWB.
- lw (0x23) with mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. memread=1 and iord=1 throughout MEMRD; memtoreg=1 in MEMWB.
- beq (0x04) -> BRANCH with aluop=1, pcwritecond=1, pcsource=1, then FETCH. j (0x02) -> pcwrite=1, pcsource=2.
- opcode=0x3F -> DECODE returns to FETCH, illegal high exactly 1 cycle. Repeat with 0x08 without the macro (illegal) and with it (states 10, 11).
- mem_ready stuck 0 in FETCH with MEM_WAIT_MAX=4 -> HALT after 5 FETCH cycles, err=1 and stays 1. Assert reset in HALT -> FETCH next cycle, err=0.
- Reset asserted during MEMWR wait -> memwrite=0 in the reset cycle, state=FETCH after.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences PC, memory port, IR, register file and the shared ALU, handshakes
// with a variable-latency memory via mem_ready, and halts on a memory timeout.
// Optional feature: define MULTICYCLE_CONTROL_ADDI_EN to decode addi (0x08)
// through the ADDIEX/ADDIWB states; otherwise 0x08 is an illegal opcode.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic [3:0] state,
  output logic       illegal,
  output logic       err
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);

  state_t           cur;
  logic [CNT_W-1:0] count;
  logic             err_q;

  // Dispatch target out of DECODE; FETCH doubles as the illegal-opcode exit.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:      decode_next = EXEC;
      OP_LW, OP_SW:  decode_next = MEMADR;
      OP_BEQ:        decode_next = BRANCH;
      OP_J:          decode_next = JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      OP_ADDI:       decode_next = ADDIEX;
`endif
      default:       decode_next = FETCH;
    endcase
  endfunction

  function automatic logic opcode_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: opcode_known = 1'b1;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      OP_ADDI:                              opcode_known = 1'b1;
`endif
      default:                              opcode_known = 1'b0;
    endcase
  endfunction

  // Where a memory-wait state goes once the access completes.
  function automatic state_t mem_done(input state_t s);
    case (s)
      FETCH:   mem_done = DECODE;
      MEMRD:   mem_done = MEMWB;
      default: mem_done = FETCH;
    endcase
  endfunction

  // State register, watchdog counter and sticky timeout flag.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur   <= FETCH;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      case (cur)
        FETCH, MEMRD, MEMWR: begin
          if (mem_ready) begin
            // A completing access beats a timeout in the same cycle.
            cur   <= mem_done(cur);
            count <= '0;
          end else if (count == WAIT_MAX) begin
            cur   <= HALT;
            count <= '0;
            err_q <= 1'b1;
          end else if (count < WAIT_MAX) begin
            count <= count + 1'b1;
          end
        end
        DECODE: begin
          cur   <= decode_next(opcode);
          count <= '0;
        end
        MEMADR: begin
          cur   <= (opcode == OP_SW) ? MEMWR : MEMRD;
          count <= '0;
        end
        EXEC: begin
          cur   <= ALUWB;
          count <= '0;
        end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        ADDIEX: begin
          cur   <= ADDIWB;
          count <= '0;
        end
`endif
        HALT: begin
          cur   <= HALT;
          count <= '0;
        end
        default: begin
          // MEMWB, ALUWB, BRANCH, JUMP, ADDIWB and unused encodings.
          cur   <= FETCH;
          count <= '0;
        end
      endcase
    end
  end

  assign state = cur;

  // Moore output decode; only FETCH looks at mem_ready, and reset forces zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'd0;
    aluop       = 2'd0;
    pcsource    = 2'd0;
    illegal     = 1'b0;
    err         = err_q & ~reset;
    if (!reset) begin
      case (cur)
        FETCH: begin
          memread = 1'b1;
          alusrcb = 2'd1;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        DECODE: begin
          alusrcb = 2'd3;
          illegal = ~opcode_known(opcode);
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'd2;
        end
        MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'd2;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'd1;
          pcwritecond = 1'b1;
          pcsource    = 2'd1;
        end
        JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'd2;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'd2;
        end
        ADDIWB: begin
          regwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (built with MEM_WAIT_MAX=4).
// The driver pushes one hand-computed expectation per cycle; a negedge
// monitor pops and compares it against the live outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal, err;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  multicycle_control #(.MEM_WAIT_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .state(state), .illegal(illegal), .err(err)
  );

  always #5 clk = ~clk;

  // Control vector bit order:
  // pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst
  // regwrite alusrca alusrcb[1:0] aluop[1:0] pcsource[1:0] illegal err
  localparam logic [17:0] C_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_ALUWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
  localparam logic [17:0] C_HALT    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
  localparam logic [17:0] C_ADDIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
`endif

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t q[$];
  int   assertions = 0;
  int   failures   = 0;

  task automatic check(input string nm, input logic [21:0] act, input logic [21:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: state/ctl got %h_%b required %h_%b",
               nm, act[21:18], act[17:0], req[21:18], req[17:0]);
    end
  endtask

  // Monitor: every cycle the DUT presents a control word; compare it mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name,
            {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
             illegal, err},
            {e.st, e.ctl});
    end
  end

  // One cycle of stimulus plus the expectation for that same cycle.
  task automatic step(input string nm, input logic rst, input logic [5:0] op,
                      input logic rdy, input logic [3:0] st, input logic [17:0] c);
    exp_t e;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    e.name = nm;
    e.st   = st;
    e.ctl  = c;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'h00;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles.
    step("reset0", 1, 6'h00, 1, 4'd0, C_ZERO);
    step("reset1", 1, 6'h00, 1, 4'd0, C_ZERO);

    // R-type: 0,1,6,7.
    step("r_fetch",  0, 6'h00, 1, 4'd0, C_FETCH_R);
    step("r_decode", 0, 6'h00, 1, 4'd1, C_DECODE);
    step("r_exec",   0, 6'h00, 1, 4'd6, C_EXEC);
    step("r_aluwb",  0, 6'h00, 1, 4'd7, C_ALUWB);

    // lw with three wait cycles in MEMRD: 0,1,2,3,3,3,3,4.
    step("lw_fetch",  0, 6'h23, 1, 4'd0, C_FETCH_R);
    step("lw_decode", 0, 6'h23, 1, 4'd1, C_DECODE);
    step("lw_memadr", 0, 6'h23, 1, 4'd2, C_MEMADR);
    step("lw_wait0",  0, 6'h23, 0, 4'd3, C_MEMRD);
    step("lw_wait1",  0, 6'h23, 0, 4'd3, C_MEMRD);
    step("lw_wait2",  0, 6'h23, 0, 4'd3, C_MEMRD);
    step("lw_rd",     0, 6'h23, 1, 4'd3, C_MEMRD);
    step("lw_memwb",  0, 6'h23, 1, 4'd4, C_MEMWB);

    // sw zero-wait: 0,1,2,5.
    step("sw_fetch",  0, 6'h2B, 1, 4'd0, C_FETCH_R);
    step("sw_decode", 0, 6'h2B, 1, 4'd1, C_DECODE);
    step("sw_memadr", 0, 6'h2B, 1, 4'd2, C_MEMADR);
    step("sw_memwr",  0, 6'h2B, 1, 4'd5, C_MEMWR);

    // beq and j.
    step("beq_fetch",  0, 6'h04, 1, 4'd0, C_FETCH_R);
    step("beq_decode", 0, 6'h04, 1, 4'd1, C_DECODE);
    step("beq_branch", 0, 6'h04, 1, 4'd8, C_BRANCH);
    step("j_fetch",    0, 6'h02, 1, 4'd0, C_FETCH_R);
    step("j_decode",   0, 6'h02, 1, 4'd1, C_DECODE);
    step("j_jump",     0, 6'h02, 1, 4'd9, C_JUMP);

    // Unknown opcode: one illegal pulse, then straight back to FETCH.
    step("ill_fetch",  0, 6'h3F, 1, 4'd0, C_FETCH_R);
    step("ill_decode", 0, 6'h3F, 1, 4'd1, C_DEC_ILL);

    // addi: decoded only with the optional feature.
    step("addi_fetch", 0, 6'h08, 1, 4'd0, C_FETCH_R);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    step("addi_decode", 0, 6'h08, 1, 4'd1,  C_DECODE);
    step("addi_ex",     0, 6'h08, 1, 4'd10, C_ADDIEX);
    step("addi_wb",     0, 6'h08, 1, 4'd11, C_ADDIWB);
`else
    step("addi_illegal", 0, 6'h08, 1, 4'd1, C_DEC_ILL);
`endif

    // FETCH waits up to the limit; ready on the final count still wins.
    step("race_w0",     0, 6'h02, 0, 4'd0, C_FETCH_W);
    step("race_w1",     0, 6'h02, 0, 4'd0, C_FETCH_W);
    step("race_w2",     0, 6'h02, 0, 4'd0, C_FETCH_W);
    step("race_w3",     0, 6'h02, 0, 4'd0, C_FETCH_W);
    step("race_ready",  0, 6'h02, 1, 4'd0, C_FETCH_R);
    step("race_decode", 0, 6'h02, 1, 4'd1, C_DECODE);
    step("race_jump",   0, 6'h02, 1, 4'd9, C_JUMP);

    // Reset during an MEMWR wait.
    step("swr_fetch",  0, 6'h2B, 1, 4'd0, C_FETCH_R);
    step("swr_decode", 0, 6'h2B, 1, 4'd1, C_DECODE);
    step("swr_memadr", 0, 6'h2B, 1, 4'd2, C_MEMADR);
    step("swr_wait",   0, 6'h2B, 0, 4'd5, C_MEMWR);
    step("swr_reset",  1, 6'h2B, 0, 4'd5, C_ZERO);

    // Memory stuck: five FETCH cycles, then HALT with sticky err.
    step("to_w0",   0, 6'h00, 0, 4'd0,  C_FETCH_W);
    step("to_w1",   0, 6'h00, 0, 4'd0,  C_FETCH_W);
    step("to_w2",   0, 6'h00, 0, 4'd0,  C_FETCH_W);
    step("to_w3",   0, 6'h00, 0, 4'd0,  C_FETCH_W);
    step("to_w4",   0, 6'h00, 0, 4'd0,  C_FETCH_W);
    step("halt0",   0, 6'h00, 0, 4'd15, C_HALT);
    step("halt1",   0, 6'h00, 1, 4'd15, C_HALT);
    step("halt2",   0, 6'h23, 1, 4'd15, C_HALT);

    // Reset out of HALT clears err and restarts at FETCH.
    step("halt_reset", 1, 6'h00, 1, 4'd15, C_ZERO);
    step("post_fetch", 0, 6'h00, 1, 4'd0,  C_FETCH_R);
    step("post_dec",   0, 6'h00, 1, 4'd1,  C_DECODE);
    step("post_exec",  0, 6'h00, 1, 4'd6,  C_EXEC);

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    assertions++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
